// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// Enum encodings are explicit so state/owner values are stable in every build.
package mem_arb_pkg;

    localparam int ARB_ADDR_W   = 32;
    localparam int ARB_DATA_W   = 32;
    localparam int ARB_BE_W     = ARB_DATA_W / 8;
    localparam int ARB_MAX_WAIT = 4;

    function automatic int wait_cnt_width(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

    localparam int WAIT_CNT_W = wait_cnt_width(ARB_MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } arb_owner_t;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [ARB_BE_W-1:0]   be;
    } mem_req_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive arbitrations lost by instruction fetch.
// at_max tells the arbiter to force the next fetch grant.
module arb_starve_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = ARB_MAX_WAIT,
    parameter int CNT_W    = WAIT_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_r;

    // Clear wins over increment; the count saturates at MAX_WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != MAX_V)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign at_max = (cnt_r == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one memory port, one transaction
// outstanding, data priority with a fetch anti-starvation override.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ARB_ADDR_W,
    parameter int DATA_W   = ARB_DATA_W,
    parameter int MAX_WAIT = ARB_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_flush,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_stall,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t state_r, state_nxt_s;
    arb_owner_t owner_r, owner_nxt_s;
    logic       killed_r, killed_nxt_s;
    logic       mem_req_r, mem_req_nxt_s;
    mem_req_t   req_r, req_nxt_s;
    logic       if_ok_s, at_max_s, inc_s, clr_s;
    logic       if_rvalid_s, d_rvalid_s;

    assign if_ok_s = if_req && !if_flush;

    arb_starve_counter #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (wait_cnt_width(MAX_WAIT))
    ) u_starve (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (inc_s),
        .clr    (clr_s),
        .at_max (at_max_s)
    );

    // Next-state, request capture and response steering.
    always_comb begin
        state_nxt_s   = state_r;
        owner_nxt_s   = owner_r;
        killed_nxt_s  = killed_r;
        mem_req_nxt_s = mem_req_r;
        req_nxt_s     = req_r;
        inc_s         = 1'b0;
        clr_s         = 1'b0;
        if_rvalid_s   = 1'b0;
        d_rvalid_s    = 1'b0;
        case (state_r)
            IDLE: begin
                killed_nxt_s = 1'b0;
                if (if_ok_s && (at_max_s || !d_req)) begin
                    req_nxt_s.we    = 1'b0;
                    req_nxt_s.addr  = ARB_ADDR_W'(if_addr);
                    req_nxt_s.wdata = '0;
                    req_nxt_s.be    = '1;
                    mem_req_nxt_s   = 1'b1;
                    owner_nxt_s     = OWN_IF;
                    state_nxt_s     = REQ;
                    clr_s           = 1'b1;
                end else if (d_req) begin
                    req_nxt_s.we    = d_we;
                    req_nxt_s.addr  = ARB_ADDR_W'(d_addr);
                    req_nxt_s.wdata = ARB_DATA_W'(d_wdata);
                    req_nxt_s.be    = d_we ? ARB_BE_W'(d_be) : '1;
                    mem_req_nxt_s   = 1'b1;
                    owner_nxt_s     = OWN_D;
                    state_nxt_s     = REQ;
                    inc_s           = if_ok_s;
                end else begin
                    owner_nxt_s     = OWN_NONE;
                end
            end
            REQ: begin
                if (if_flush && (owner_r == OWN_IF)) begin
                    killed_nxt_s = 1'b1;
                end else begin
                    killed_nxt_s = killed_r;
                end
                if (mem_gnt) begin
                    mem_req_nxt_s = 1'b0;
                    state_nxt_s   = RESP;
                end else begin
                    state_nxt_s   = REQ;
                end
            end
            RESP: begin
                if (if_flush && (owner_r == OWN_IF)) begin
                    killed_nxt_s = 1'b1;
                end else begin
                    killed_nxt_s = killed_r;
                end
                // A flush arriving with the response still kills the fetch.
                if (mem_rvalid) begin
                    if_rvalid_s  = (owner_r == OWN_IF) && !killed_r && !if_flush;
                    d_rvalid_s   = (owner_r == OWN_D);
                    owner_nxt_s  = OWN_NONE;
                    killed_nxt_s = 1'b0;
                    state_nxt_s  = IDLE;
                end else begin
                    state_nxt_s  = RESP;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                owner_nxt_s   = OWN_NONE;
                killed_nxt_s  = 1'b0;
                mem_req_nxt_s = 1'b0;
            end
        endcase
    end

    // State and downstream request registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            owner_r   <= OWN_NONE;
            killed_r  <= 1'b0;
            mem_req_r <= 1'b0;
            req_r     <= '0;
        end else begin
            state_r   <= state_nxt_s;
            owner_r   <= owner_nxt_s;
            killed_r  <= killed_nxt_s;
            mem_req_r <= mem_req_nxt_s;
            req_r     <= req_nxt_s;
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = req_r.we;
    assign mem_addr  = ADDR_W'(req_r.addr);
    assign mem_wdata = DATA_W'(req_r.wdata);
    assign mem_be    = BE_W'(req_r.be);

    assign if_rvalid = if_rvalid_s;
    assign d_rvalid  = d_rvalid_s;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign if_stall  = if_req && !if_rvalid_s;
    assign d_stall   = d_req && !d_rvalid_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench: expected issues/responses are queued as stimulus
// is driven and checked when the DUT issues to memory or returns data.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        if_req, if_flush, if_rvalid, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_rvalid, d_stall;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;} iss_t;
    typedef struct {bit is_if; logic [31:0] data; bit chk_data;} rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    iss_t d_pend[$];
    int   checks = 0;
    int   failures = 0;
    int   gnt_dly = 1;
    int   rsp_dly = 1;
    int   stray_cnt = 0;
    int   if_rsp_n = 0, d_rsp_n = 0;
    int   if_seen = 0, d_seen = 0;
    logic prev_req = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_if(input logic [31:0] a, input bit want_rsp);
        iss_q.push_back('{we: 1'b0, addr: a, wdata: 32'h0, be: 4'hF});
        if (want_rsp) rsp_q.push_back('{is_if: 1'b1, data: mem_data(a), chk_data: 1'b1});
    endtask

    task automatic exp_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        iss_q.push_back('{we: we, addr: a, wdata: wd, be: (we ? be : 4'hF)});
        rsp_q.push_back('{is_if: 1'b0, data: mem_data(a), chk_data: !we});
        d_pend.push_back('{we: we, addr: a, wdata: wd, be: be});
    endtask

    task automatic load_d();
        iss_t e;
        if (d_pend.size() != 0) begin
            e = d_pend.pop_front();
            d_req = 1'b1; d_we = e.we; d_addr = e.addr; d_wdata = e.wdata; d_be = e.be;
        end else begin
            d_req = 1'b0;
        end
    endtask

    // Requesters drop/advance right after the edge that saw their rvalid.
    task automatic tick();
        @(posedge clk); #1;
        if (if_rsp_n != if_seen) begin if_seen = if_rsp_n; if_req = 1'b0; end
        if (d_rsp_n != d_seen) begin d_seen = d_rsp_n; load_d(); end
    endtask

    task automatic drain(input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc; i++) begin
            if (rsp_q.size() == 0 && iss_q.size() == 0 && !if_req && !d_req) break;
            tick();
        end
        chk(tag, 64'(rsp_q.size() + iss_q.size()), 64'd0);
        tick();
    endtask

    // Downstream memory model: grant after gnt_dly, respond rsp_dly after grant.
    initial begin
        int   phase;
        int   wcnt;
        int   stray_done;
        logic [31:0] raddr;
        phase = 0; wcnt = 0; stray_done = 0; raddr = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        forever begin
            @(posedge clk); #2;
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (!rst_n) begin
                phase = 0;
            end else if (stray_done != stray_cnt) begin
                stray_done++;
                mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
            end else begin
                if (phase == 0 && mem_req) begin phase = 1; wcnt = 0; end
                if (phase == 1) begin
                    if (wcnt >= gnt_dly) begin
                        mem_gnt = 1'b1; raddr = mem_addr; phase = 2; wcnt = 0;
                    end else wcnt++;
                end else if (phase == 2) begin
                    wcnt++;
                    if (wcnt >= rsp_dly) begin
                        mem_rvalid = 1'b1; mem_rdata = mem_data(raddr); phase = 0;
                    end
                end
            end
        end
    end

    // Scoreboard monitor on the falling edge.
    initial begin
        iss_t e;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (mem_req && !prev_req) begin
                chk("issue_expected", 64'(iss_q.size() != 0), 64'd1);
                if (iss_q.size() != 0) begin
                    e = iss_q.pop_front();
                    chk("mem_we", 64'(mem_we), 64'(e.we));
                    chk("mem_addr", 64'(mem_addr), 64'(e.addr));
                    chk("mem_be", 64'(mem_be), 64'(e.be));
                    if (e.we) chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
                end
            end
            prev_req = mem_req;
            if (if_rvalid || d_rvalid) begin
                chk("rsp_expected", 64'(rsp_q.size() != 0), 64'd1);
                if (rsp_q.size() != 0) begin
                    r = rsp_q.pop_front();
                    chk("rsp_port_if", 64'(if_rvalid), 64'(r.is_if));
                    chk("rsp_port_d", 64'(d_rvalid), 64'(!r.is_if));
                    if (r.chk_data) chk("rsp_data", 64'(r.is_if ? if_rdata : d_rdata), 64'(r.data));
                end
            end
            if (if_rvalid) if_rsp_n++;
            if (d_rvalid) d_rsp_n++;
            chk("if_stall", 64'(if_stall), 64'(if_req && !if_rvalid));
            chk("d_stall", 64'(d_stall), 64'(d_req && !d_rvalid));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int mx;
        rst_n = 1'b0; if_req = 1'b0; if_addr = 32'h0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_be", 64'(mem_be), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_state", 64'(dut.state_r), 64'(IDLE));

        // Single fetch, grant two cycles after request.
        gnt_dly = 2; rsp_dly = 1;
        exp_if(32'h100, 1'b1);
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        chk("fetch_stall_pending", 64'(if_stall), 64'd1);
        drain(50, "drain_fetch");

        // Simultaneous fetch and load: data goes first.
        gnt_dly = 0; rsp_dly = 2;
        exp_d(1'b0, 32'h800, 32'h0, 4'h0);
        exp_if(32'h200, 1'b1);
        load_d();
        if_req = 1'b1; if_addr = 32'h200;
        for (int i = 0; i < 20 && !mem_req; i++) tick();
        chk("simul_issue_seen", 64'(mem_req), 64'd1);
        chk("simul_wait_cnt", 64'(dut.u_starve.cnt_r), 64'd1);
        drain(80, "drain_simul");

        // Starvation: back-to-back loads with a pending fetch.
        gnt_dly = 0; rsp_dly = 1;
        for (int i = 0; i < 4; i++) exp_d(1'b0, 32'h1000 + 32'(4 * i), 32'h0, 4'h0);
        exp_if(32'h300, 1'b1);
        exp_d(1'b0, 32'h1010, 32'h0, 4'h0);
        load_d();
        if_req = 1'b1; if_addr = 32'h300;
        mx = 0;
        for (int i = 0; i < 100 && !(mem_req && mem_addr == 32'h300); i++) begin
            tick();
            if (int'(dut.u_starve.cnt_r) > mx) mx = int'(dut.u_starve.cnt_r);
        end
        chk("starve_if_issued", 64'(mem_req && mem_addr == 32'h300), 64'd1);
        chk("starve_max_wait", 64'(mx), 64'd4);
        chk("starve_cnt_cleared", 64'(dut.u_starve.cnt_r), 64'd0);
        drain(100, "drain_starve");

        // Flush one cycle before the fetch response.
        gnt_dly = 0; rsp_dly = 3;
        exp_if(32'h340, 1'b0);
        if_req = 1'b1; if_addr = 32'h340;
        tick(); tick(); tick();
        if_flush = 1'b1;
        tick();
        chk("flush_killed", 64'(dut.killed_r), 64'd1);
        if_flush = 1'b0; if_req = 1'b0;
        exp_d(1'b0, 32'h900, 32'h0, 4'h0);
        load_d();
        tick(); tick();
        chk("flush_next_d_req", 64'(mem_req), 64'd1);
        chk("flush_next_d_addr", 64'(mem_addr), 64'h900);
        drain(50, "drain_flush");

        // Flush in the same cycle as the fetch response.
        exp_if(32'h380, 1'b0);
        if_req = 1'b1; if_addr = 32'h380;
        tick(); tick(); tick(); tick();
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0; if_req = 1'b0;
        drain(50, "drain_flush_same");

        // Store: exact byte enables and data, ack on rvalid.
        gnt_dly = 1; rsp_dly = 1;
        exp_d(1'b1, 32'h40, 32'h12345678, 4'h3);
        load_d();
        drain(50, "drain_store");

        // Reset while a request is waiting for grant, then a stray response.
        gnt_dly = 50;
        iss_q.push_back('{we: 1'b0, addr: 32'h700, wdata: 32'h0, be: 4'hF});
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700; d_wdata = 32'h0; d_be = 4'h0;
        for (int i = 0; i < 10 && !mem_req; i++) tick();
        chk("rstmid_req_up", 64'(mem_req), 64'd1);
        d_req = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rstmid_mem_req", 64'(mem_req), 64'd0);
        chk("rstmid_state", 64'(dut.state_r), 64'(IDLE));
        gnt_dly = 1;
        stray_cnt = 1;
        repeat (4) tick();
        chk("final_queues", 64'(iss_q.size() + rsp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
